// File: rtl/ddr4_traffic_checker_if.sv
// ddr4_traffic_checker_if
// Memory-controller application (app) bus between the traffic checker and
// the calibrated DDR4 controller.
//   master modport : traffic checker (drives commands and write data)
//   slave modport  : memory controller (drives readies and read data)
// Signals:
//   app_en/app_cmd/app_addr/app_rdy          command channel
//   app_wdf_wren/_end/_data/_mask/app_wdf_rdy write-data channel
//   app_rd_data/app_rd_data_valid            read-return channel
interface ddr4_traffic_checker_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 512
);
    logic                      app_rdy;
    logic                      app_en;
    logic [2:0]                app_cmd;
    logic [ADDR_WIDTH-1:0]     app_addr;
    logic                      app_wdf_rdy;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic [DATA_WIDTH-1:0]     app_wdf_data;
    logic [DATA_WIDTH/8-1:0]   app_wdf_mask;
    logic [DATA_WIDTH-1:0]     app_rd_data;
    logic                      app_rd_data_valid;

    modport master (
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );

    modport slave (
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );
endinterface

// File: rtl/ddr4_traffic_checker.sv
// ddr4_traffic_checker
// After calibration, writes a deterministic pattern over NUM_BURSTS bursts
// (address k*BURST_STRIDE), reads it back and compares every beat. The first
// mismatch since reset sets a sticky error and captures its address.
// Ports:
//   core_clk, sys_rst_n      clock, asynchronous active-low reset
//   init_calib_complete      controller calibrated; a fall restarts the test
//   app                      app bus (master side)
//   data_compare_error       sticky mismatch flag
//   err_addr                 address of first mismatch
//   test_done                a full pass has completed
//   pass_count               completed passes (wraps)
// Build option: DDR4_TG_LOOP_EN -- when defined, DONE loops back to WRITE and
// each new pass writes the inverted pattern; otherwise DONE is terminal.
module ddr4_traffic_checker #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 512,
    parameter int NUM_BURSTS   = 1024,
    parameter int BURST_STRIDE = 8
) (
    input  logic                  core_clk,
    input  logic                  sys_rst_n,
    input  logic                  init_calib_complete,
    ddr4_traffic_checker_if.master app,
    output logic                  data_compare_error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  test_done,
    output logic [15:0]           pass_count
);
    localparam int LANES = DATA_WIDTH / 32;
    localparam int CNT_W = $clog2(NUM_BURSTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BURSTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        wdata_cnt_q, wdata_cnt_d;
    logic [CNT_W-1:0]        cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]        rd_ret_cnt_q, rd_ret_cnt_d;
    logic                    app_en_q, app_en_d;
    logic [2:0]              app_cmd_q, app_cmd_d;
    logic [ADDR_WIDTH-1:0]   app_addr_q, app_addr_d;
    logic                    app_wdf_wren_q, app_wdf_wren_d;
    logic [DATA_WIDTH-1:0]   app_wdf_data_q, app_wdf_data_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic                    test_done_q, test_done_d;
    logic [15:0]             pass_count_q, pass_count_d;

    logic                    cmd_fire, wdata_fire, rd_fire, calib_lost;
    logic [23:0]             wr_a24, rd_a24;
    logic [DATA_WIDTH-1:0]   wr_pattern, exp_pattern;
    logic                    pat_inv;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [CNT_W-1:0] k);
        return ADDR_WIDTH'(k) * ADDR_WIDTH'(BURST_STRIDE);
    endfunction

    assign cmd_fire   = app_en_q && app.app_rdy;
    assign wdata_fire = app_wdf_wren_q && app.app_wdf_rdy;
    // Read returns are only meaningful while reads are in flight.
    assign rd_fire    = app.app_rd_data_valid && (state_q == S_READ || state_q == S_WAIT_RD);
    assign calib_lost = (state_q != S_IDLE) && !init_calib_complete;

    // Pass parity follows the completed-pass count, so pass 0 is plain and
    // every following pass alternates inversion.
    assign pat_inv = pass_count_q[0];
    assign wr_a24  = 24'(burst_addr(wdata_cnt_d));
    assign rd_a24  = 24'(burst_addr(rd_ret_cnt_q));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_pattern[gi*32 +: 32]  = {wr_a24, 8'(gi)} ^ {32{pat_inv}};
            assign exp_pattern[gi*32 +: 32] = {rd_a24, 8'(gi)} ^ {32{pat_inv}};
        end
    endgenerate

    // State and counter register.
    always_ff @(posedge core_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            wdata_cnt_q  <= '0;
            cmd_cnt_q    <= '0;
            rd_ret_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wdata_cnt_q  <= wdata_cnt_d;
            cmd_cnt_q    <= cmd_cnt_d;
            rd_ret_cnt_q <= rd_ret_cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d      = state_q;
        wdata_cnt_d  = wdata_cnt_q;
        cmd_cnt_d    = cmd_cnt_q;
        rd_ret_cnt_d = rd_ret_cnt_q;
        if (calib_lost) begin
            state_d      = S_IDLE;
            wdata_cnt_d  = '0;
            cmd_cnt_d    = '0;
            rd_ret_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init_calib_complete) state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (wdata_fire) wdata_cnt_d = wdata_cnt_q + CNT_ONE;
                    if (cmd_fire)   cmd_cnt_d   = cmd_cnt_q + CNT_ONE;
                    if (cmd_cnt_d == CNT_LAST) begin
                        state_d     = S_READ;
                        cmd_cnt_d   = '0;
                        wdata_cnt_d = '0;
                    end
                end
                S_READ: begin
                    if (cmd_fire) cmd_cnt_d    = cmd_cnt_q + CNT_ONE;
                    if (rd_fire)  rd_ret_cnt_d = rd_ret_cnt_q + CNT_ONE;
                    if (cmd_cnt_d == CNT_LAST) begin
                        if (rd_ret_cnt_d == CNT_LAST) begin
                            state_d      = S_DONE;
                            cmd_cnt_d    = '0;
                            rd_ret_cnt_d = '0;
                        end else begin
                            state_d = S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (rd_fire) rd_ret_cnt_d = rd_ret_cnt_q + CNT_ONE;
                    if (rd_ret_cnt_d == CNT_LAST) begin
                        state_d      = S_DONE;
                        cmd_cnt_d    = '0;
                        rd_ret_cnt_d = '0;
                    end
                end
                S_DONE: begin
`ifdef DDR4_TG_LOOP_EN
                    state_d = S_WRITE;
`else
                    state_d = S_DONE;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output next-state logic. Bus outputs are derived from the next state and
    // next counters so they are registered yet present in the cycle the state
    // is entered; while a ready is low the counters hold, so the outputs hold.
    always_comb begin
        app_en_d       = 1'b0;
        app_cmd_d      = CMD_WRITE;
        app_wdf_wren_d = 1'b0;
        case (state_d)
            S_WRITE: begin
                app_wdf_wren_d = (wdata_cnt_d < CNT_LAST);
                // A write command is issued only after its data was accepted.
                app_en_d       = (cmd_cnt_d < wdata_cnt_d);
            end
            S_READ: begin
                app_en_d  = (cmd_cnt_d < CNT_LAST);
                app_cmd_d = CMD_READ;
            end
            default: ;
        endcase
        app_addr_d     = app_en_d ? burst_addr(cmd_cnt_d) : '0;
        app_wdf_data_d = app_wdf_wren_d ? wr_pattern : '0;

        test_done_d  = test_done_q;
        pass_count_d = pass_count_q;
        if (calib_lost) begin
            test_done_d = 1'b0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            test_done_d  = 1'b1;
            pass_count_d = pass_count_q + 16'd1;
        end

        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (rd_fire && !err_q && (app.app_rd_data != exp_pattern)) begin
            err_d      = 1'b1;
            err_addr_d = burst_addr(rd_ret_cnt_q);
        end
    end

    // Output register.
    always_ff @(posedge core_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            app_en_q       <= 1'b0;
            app_cmd_q      <= '0;
            app_addr_q     <= '0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_data_q <= '0;
            err_q          <= 1'b0;
            err_addr_q     <= '0;
            test_done_q    <= 1'b0;
            pass_count_q   <= '0;
        end else begin
            app_en_q       <= app_en_d;
            app_cmd_q      <= app_cmd_d;
            app_addr_q     <= app_addr_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_wdf_data_q <= app_wdf_data_d;
            err_q          <= err_d;
            err_addr_q     <= err_addr_d;
            test_done_q    <= test_done_d;
            pass_count_q   <= pass_count_d;
        end
    end

    assign app.app_en       = app_en_q;
    assign app.app_cmd      = app_cmd_q;
    assign app.app_addr     = app_addr_q;
    assign app.app_wdf_wren = app_wdf_wren_q;
    assign app.app_wdf_end  = app_wdf_wren_q;
    assign app.app_wdf_data = app_wdf_data_q;
    assign app.app_wdf_mask = '0;

    assign data_compare_error = err_q;
    assign err_addr           = err_addr_q;
    assign test_done          = test_done_q;
    assign pass_count         = pass_count_q;
endmodule

// File: tb/tb_ddr4_traffic_checker.sv
module tb_ddr4_traffic_checker;
    localparam int AW = 28;
    localparam int DW = 512;

    logic          core_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          init_calib_complete = 1'b0;
    logic          data_compare_error;
    logic [AW-1:0] err_addr;
    logic          test_done;
    logic [15:0]   pass_count;

    ddr4_traffic_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ddr4_traffic_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BURSTS(4), .BURST_STRIDE(8)
    ) dut (
        .core_clk(core_clk),
        .sys_rst_n(sys_rst_n),
        .init_calib_complete(init_calib_complete),
        .app(bus),
        .data_compare_error(data_compare_error),
        .err_addr(err_addr),
        .test_done(test_done),
        .pass_count(pass_count)
    );

    always #5 core_clk = ~core_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    // Memory model state
    logic [DW-1:0] mem [0:31];
    int            q_wa[$];
    logic [DW-1:0] q_wd[$];
    int            q_ra[$];
    int            wr_log[$];
    bit            stall_en = 0;
    bit            corrupt_en = 0;
    int            wcmd_acc, wdata_acc, rd_cmds, beats;
    int            stall_viol, order_viol;
    int            done_cyc, err_cyc, bad16_cyc, last_beat_cyc;
    bit            prev_cmd_stall, prev_wd_stall;
    logic [AW-1:0] prev_addr;
    logic [2:0]    prev_cmd;
    logic [DW-1:0] prev_data;
    int            m_a;
    logic [DW-1:0] m_d;
    bit            cmd_fire, wd_fire;

    function automatic logic [DW-1:0] exp_word(input int addr, input bit inv);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = {addr[23:0], i[7:0]};
        if (inv) w = ~w;
        return w;
    endfunction

    // Controller/memory model: drives readies and read returns on the falling
    // edge and records handshakes that will complete on the next rising edge.
    always @(negedge core_clk) begin
        if (!sys_rst_n) begin
            bus.app_rdy = 1'b0;
            bus.app_wdf_rdy = 1'b0;
            bus.app_rd_data_valid = 1'b0;
            bus.app_rd_data = '0;
            prev_cmd_stall = 1'b0;
            prev_wd_stall = 1'b0;
        end else begin
            bus.app_rd_data_valid = 1'b0;
            if (q_ra.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
                m_a = q_ra.pop_front();
                m_d = mem[m_a >> 3];
                if (corrupt_en && m_a == 16) begin
                    m_d[5] = ~m_d[5];
                    if (bad16_cyc < 0) bad16_cyc = cyc;
                end
                if (corrupt_en && m_a == 24) m_d[100] = ~m_d[100];
                bus.app_rd_data = m_d;
                bus.app_rd_data_valid = 1'b1;
                beats++;
                last_beat_cyc = cyc;
                $display("cyc=%0d RD_BEAT addr=%0d lane0=%h", cyc, m_a, m_d[31:0]);
            end
            if (prev_cmd_stall && (bus.app_en !== 1'b1 || bus.app_addr !== prev_addr || bus.app_cmd !== prev_cmd))
                stall_viol++;
            if (prev_wd_stall && (bus.app_wdf_wren !== 1'b1 || bus.app_wdf_data !== prev_data))
                stall_viol++;
            bus.app_rdy     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.app_wdf_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_fire = bus.app_en && bus.app_rdy;
            wd_fire  = bus.app_wdf_wren && bus.app_wdf_rdy;
            if (cmd_fire && bus.app_cmd == 3'b000) begin
                if (wcmd_acc >= wdata_acc) order_viol++;
                wcmd_acc++;
                q_wa.push_back(int'(bus.app_addr));
                wr_log.push_back(int'(bus.app_addr));
                $display("cyc=%0d WR_CMD addr=%0d", cyc, bus.app_addr);
            end
            if (cmd_fire && bus.app_cmd == 3'b001) begin
                rd_cmds++;
                q_ra.push_back(int'(bus.app_addr));
                $display("cyc=%0d RD_CMD addr=%0d", cyc, bus.app_addr);
            end
            if (wd_fire) begin
                wdata_acc++;
                q_wd.push_back(bus.app_wdf_data);
                $display("cyc=%0d WR_DATA lane0=%h", cyc, bus.app_wdf_data[31:0]);
            end
            while (q_wa.size() > 0 && q_wd.size() > 0) begin
                m_a = q_wa.pop_front();
                mem[m_a >> 3] = q_wd.pop_front();
            end
            prev_cmd_stall = bus.app_en && !bus.app_rdy;
            prev_wd_stall  = bus.app_wdf_wren && !bus.app_wdf_rdy;
            prev_addr = bus.app_addr;
            prev_cmd  = bus.app_cmd;
            prev_data = bus.app_wdf_data;
            if (test_done && done_cyc < 0) done_cyc = cyc;
            if (data_compare_error && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic apply_reset;
        sys_rst_n = 1'b0;
        init_calib_complete = 1'b0;
        stall_en = 0;
        corrupt_en = 0;
        repeat (2) @(posedge core_clk);
        #1;
        q_wa.delete(); q_wd.delete(); q_ra.delete(); wr_log.delete();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        wcmd_acc = 0; wdata_acc = 0; rd_cmds = 0; beats = 0;
        stall_viol = 0; order_viol = 0;
        done_cyc = -1; err_cyc = -1; bad16_cyc = -1; last_beat_cyc = -1;
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (test_done !== 1'b1 && n < limit) begin
            @(posedge core_clk);
            #1;
            n++;
        end
        total++;
        if (test_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: test_done=%b required 1", tag, test_done);
        end
        @(negedge core_clk);
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        repeat (10) @(posedge core_clk);
        #1;
        total++; if (bus.app_en !== 1'b0) begin bad++; $display("FAIL rst_app_en: got %b required 0", bus.app_en); end
        total++; if (bus.app_cmd !== 3'b000) begin bad++; $display("FAIL rst_app_cmd: got %h required 0", bus.app_cmd); end
        total++; if (bus.app_addr !== '0) begin bad++; $display("FAIL rst_app_addr: got %h required 0", bus.app_addr); end
        total++; if (bus.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL rst_wren: got %b required 0", bus.app_wdf_wren); end
        total++; if (bus.app_wdf_end !== 1'b0) begin bad++; $display("FAIL rst_wdf_end: got %b required 0", bus.app_wdf_end); end
        total++; if (bus.app_wdf_data !== '0) begin bad++; $display("FAIL rst_wdf_data: lane0 got %h required 0", bus.app_wdf_data[31:0]); end
        total++; if (bus.app_wdf_mask !== '0) begin bad++; $display("FAIL rst_wdf_mask: got %h required 0", bus.app_wdf_mask); end
        total++; if (data_compare_error !== 1'b0) begin bad++; $display("FAIL rst_err: got %b required 0", data_compare_error); end
        total++; if (err_addr !== '0) begin bad++; $display("FAIL rst_err_addr: got %h required 0", err_addr); end
        total++; if (test_done !== 1'b0) begin bad++; $display("FAIL rst_test_done: got %b required 0", test_done); end
        total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL rst_pass_count: got %0d required 0", pass_count); end
    endtask

    task automatic test_first_write;
        @(negedge core_clk);
        total++; if (bus.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL pre_calib_wren: got %b required 0", bus.app_wdf_wren); end
        init_calib_complete = 1'b1;
        @(posedge core_clk);
        #1;
        total++; if (bus.app_wdf_wren !== 1'b1) begin bad++; $display("FAIL first_wren: got %b required 1", bus.app_wdf_wren); end
        total++; if (bus.app_wdf_end !== 1'b1) begin bad++; $display("FAIL first_wdf_end: got %b required 1", bus.app_wdf_end); end
        total++; if (bus.app_wdf_data !== exp_word(0, 0)) begin bad++; $display("FAIL first_wdata: lane1 got %h required %h", bus.app_wdf_data[63:32], 32'h00000001); end
        total++; if (bus.app_en !== 1'b0) begin bad++; $display("FAIL cmd_before_data: app_en got %b required 0", bus.app_en); end
    endtask

    task automatic test_ideal_pass;
        wait_done(200, "ideal");
        total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL ideal_pass_count: got %0d required 1", pass_count); end
        total++; if (data_compare_error !== 1'b0) begin bad++; $display("FAIL ideal_err: got %b required 0", data_compare_error); end
        total++; if (done_cyc !== last_beat_cyc + 1) begin bad++; $display("FAIL done_latency: done at %0d required %0d", done_cyc, last_beat_cyc + 1); end
        total++; if (wr_log.size() !== 4) begin bad++; $display("FAIL ideal_wr_count: got %0d required 4", wr_log.size()); end
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            total++; if (wr_log[k] !== k * 8) begin bad++; $display("FAIL wr_addr_%0d: got %0d required %0d", k, wr_log[k], k * 8); end
        end
        m_d = mem[1];
        total++; if (m_d[31:0] !== 32'h00000800) begin bad++; $display("FAIL lane0_addr8: got %h required 00000800", m_d[31:0]); end
        total++; if (mem[2] !== exp_word(16, 0)) begin bad++; $display("FAIL word_addr16: lane0 got %h required 00001000", mem[2][31:0]); end
        total++; if (rd_cmds !== 4 || beats !== 4) begin bad++; $display("FAIL ideal_reads: cmds=%0d beats=%0d required 4/4", rd_cmds, beats); end
`ifndef DDR4_TG_LOOP_EN
        repeat (20) @(posedge core_clk);
        #1;
        total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL terminal_pass_count: got %0d required 1", pass_count); end
        total++; if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL terminal_idle_bus: en=%b wren=%b required 0/0", bus.app_en, bus.app_wdf_wren); end
        total++; if (test_done !== 1'b1) begin bad++; $display("FAIL terminal_done: got %b required 1", test_done); end
`endif
    endtask

`ifdef DDR4_TG_LOOP_EN
    task automatic test_loop;
        int n = 0;
        while (pass_count !== 16'd2 && n < 200) begin
            @(posedge core_clk);
            #1;
            n++;
        end
        total++; if (pass_count !== 16'd2) begin bad++; $display("FAIL loop_pass_count: got %0d required 2", pass_count); end
        m_d = mem[0];
        total++; if (m_d[31:0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL loop_lane0_addr0: got %h required ffffffff", m_d[31:0]); end
        total++; if (data_compare_error !== 1'b0) begin bad++; $display("FAIL loop_err: got %b required 0", data_compare_error); end
        total++; if (test_done !== 1'b1) begin bad++; $display("FAIL loop_done: got %b required 1", test_done); end
    endtask
`endif

    task automatic test_stalls;
        apply_reset();
        stall_en = 1;
        @(negedge core_clk);
        init_calib_complete = 1'b1;
        wait_done(3000, "stall");
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_stability: violations=%0d required 0", stall_viol); end
        total++; if (order_viol !== 0) begin bad++; $display("FAIL cmd_after_data: violations=%0d required 0", order_viol); end
        total++; if (data_compare_error !== 1'b0) begin bad++; $display("FAIL stall_err: got %b required 0", data_compare_error); end
        total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL stall_pass_count: got %0d required 1", pass_count); end
        total++; if (mem[3] !== exp_word(24, 0)) begin bad++; $display("FAIL stall_word_addr24: lane0 got %h required 00001800", mem[3][31:0]); end
    endtask

    task automatic test_corrupt;
        apply_reset();
        corrupt_en = 1;
        @(negedge core_clk);
        init_calib_complete = 1'b1;
        wait_done(200, "corrupt");
        total++; if (data_compare_error !== 1'b1) begin bad++; $display("FAIL corrupt_err: got %b required 1", data_compare_error); end
        total++; if (err_addr !== 28'd16) begin bad++; $display("FAIL corrupt_err_addr: got %0d required 16", err_addr); end
        total++; if (err_cyc !== bad16_cyc + 1) begin bad++; $display("FAIL err_latency: err at %0d required %0d", err_cyc, bad16_cyc + 1); end
        total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL corrupt_pass_count: got %0d required 1", pass_count); end
    endtask

    task automatic test_calib_drop;
        int n = 0;
        apply_reset();
        @(negedge core_clk);
        init_calib_complete = 1'b1;
        while (!(bus.app_en === 1'b1 && bus.app_cmd === 3'b001) && n < 200) begin
            @(posedge core_clk);
            #1;
            n++;
        end
        total++; if (bus.app_cmd !== 3'b001) begin bad++; $display("FAIL reach_read: app_cmd got %h required 1", bus.app_cmd); end
        @(negedge core_clk);
        init_calib_complete = 1'b0;
        repeat (6) @(posedge core_clk);
        #1;
        total++; if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL drop_bus_idle: en=%b wren=%b required 0/0", bus.app_en, bus.app_wdf_wren); end
        total++; if (test_done !== 1'b0) begin bad++; $display("FAIL drop_test_done: got %b required 0", test_done); end
        total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL drop_pass_count: got %0d required 0", pass_count); end
        q_ra.delete(); q_wa.delete(); q_wd.delete(); wr_log.delete();
        wcmd_acc = 0; wdata_acc = 0;
        @(negedge core_clk);
        init_calib_complete = 1'b1;
        wait_done(200, "restart");
        total++; if (wr_log.size() !== 4) begin bad++; $display("FAIL restart_wr_count: got %0d required 4", wr_log.size()); end
        total++; if (wr_log.size() > 0 && wr_log[0] !== 0) begin bad++; $display("FAIL restart_first_addr: got %0d required 0", wr_log[0]); end
        total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL restart_pass_count: got %0d required 1", pass_count); end
        total++; if (data_compare_error !== 1'b0) begin bad++; $display("FAIL restart_err: got %b required 0", data_compare_error); end
    endtask

    task automatic test_async_reset;
        apply_reset();
        @(negedge core_clk);
        init_calib_complete = 1'b1;
        repeat (2) @(posedge core_clk);
        #1;
        total++; if (bus.app_en !== 1'b1 || bus.app_wdf_wren !== 1'b1) begin bad++; $display("FAIL pre_async_active: en=%b wren=%b required 1/1", bus.app_en, bus.app_wdf_wren); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++; if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) begin bad++; $display("FAIL async_drop: en=%b wren=%b required 0/0", bus.app_en, bus.app_wdf_wren); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_ideal_pass();
`ifdef DDR4_TG_LOOP_EN
        test_loop();
`endif
        test_stalls();
        test_corrupt();
        test_calib_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
